// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the pixel-core cache read controller.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MREQ,
        MWAIT,
        FILL,
        RESP
    } state_t;

    localparam int CNT_W = 32;

    function automatic int bytes_per_block(input int size_block);
        return size_block / 8;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: first requester at or after the rotating pointer wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             adv_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Walk offsets from the far end down so the nearest requester to ptr is kept.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_q) + i) % N_REQ]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IDX_W'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    assign ptr_d = IDX_W'((int'(gnt_idx_o) + 1) % N_REQ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cache_rd_ctrl.sv
// Read-path controller: arbitrates requesters onto the cache port and fills
// misses from SDRAM through an Avalon-MM read master, one transaction at a time.
module cache_rd_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int SIZE_BLOCK = 32,
    parameter int BIT_TOTAL  = 24,
    parameter int BIT_MEM    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [BIT_MEM-1:0]       i_base_addr,
    input  logic [N_REQ-1:0]         i_req_read,
    input  logic [N_REQ*BIT_TOTAL-1:0] i_req_addr,
    output logic [N_REQ-1:0]         o_req_waitrequest,
    output logic [N_REQ-1:0]         o_req_readdatavalid,
    output logic [SIZE_BLOCK-1:0]    o_req_readdata,
    output logic                     o_c_en,
    output logic                     o_c_wrt,
    output logic [BIT_TOTAL-1:0]     o_c_addr,
    output logic [SIZE_BLOCK-1:0]    o_c_data,
    input  logic [SIZE_BLOCK-1:0]    i_c_data,
    input  logic                     i_c_success,
    output logic                     o_m_read,
    output logic [BIT_MEM-1:0]       o_m_address,
    input  logic                     i_m_waitrequest,
    input  logic [SIZE_BLOCK-1:0]    i_m_readdata,
    input  logic                     i_m_readdatavalid,
    output logic [CNT_W-1:0]         o_hit_cnt,
    output logic [CNT_W-1:0]         o_miss_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BPB   = bytes_per_block(SIZE_BLOCK);

    state_t                 state_q;
    logic [IDX_W-1:0]       id_q;
    logic [BIT_TOTAL-1:0]   addr_q;
    logic                   c_en_q, c_wrt_q, m_read_q;
    logic [BIT_TOTAL-1:0]   c_addr_q;
    logic [SIZE_BLOCK-1:0]  c_data_q, rdata_q;
    logic [BIT_MEM-1:0]     m_addr_q, m_addr_d;
    logic [N_REQ-1:0]       rvalid_q;
    logic [CNT_W-1:0]       hit_q, miss_q;

    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_vld;
    logic                   accept;
    logic [BIT_TOTAL-1:0]   gnt_addr;

    // Acceptance is suppressed while reset is held so waitrequest stays all-ones.
    assign accept   = !i_rst && (state_q == IDLE) && gnt_vld;
    assign gnt_addr = i_req_addr[int'(gnt_idx)*BIT_TOTAL +: BIT_TOTAL];
    assign m_addr_d = i_base_addr + BIT_MEM'(addr_q) * BIT_MEM'(BPB);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .req_i     (i_req_read),
        .adv_i     (accept),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        o_req_waitrequest = '1;
        if (accept) o_req_waitrequest[gnt_idx] = 1'b0;
    end

    // Outputs are registered, so each is set on the transition into the state that owns it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            c_en_q   <= 1'b0;
            c_wrt_q  <= 1'b0;
            c_addr_q <= '0;
            c_data_q <= '0;
            m_read_q <= 1'b0;
            m_addr_q <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            c_en_q   <= 1'b0;
            c_wrt_q  <= 1'b0;
            rvalid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        id_q     <= gnt_idx;
                        addr_q   <= gnt_addr;
                        c_en_q   <= 1'b1;
                        c_addr_q <= gnt_addr;
                        state_q  <= LOOKUP;
                    end
                end
                LOOKUP: state_q <= CHECK;
                CHECK: begin
                    if (i_c_success) begin
                        hit_q          <= hit_q + CNT_W'(1);
                        rvalid_q[id_q] <= 1'b1;
                        rdata_q        <= i_c_data;
                        state_q        <= RESP;
                    end else begin
                        miss_q   <= miss_q + CNT_W'(1);
                        m_read_q <= 1'b1;
                        m_addr_q <= m_addr_d;
                        state_q  <= MREQ;
                    end
                end
                MREQ: begin
                    if (!i_m_waitrequest) begin
                        m_read_q <= 1'b0;
                        state_q  <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (i_m_readdatavalid) begin
                        c_en_q   <= 1'b1;
                        c_wrt_q  <= 1'b1;
                        c_addr_q <= addr_q;
                        c_data_q <= i_m_readdata;
                        state_q  <= FILL;
                    end
                end
                FILL: begin
                    rvalid_q[id_q] <= 1'b1;
                    rdata_q        <= c_data_q;
                    state_q        <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_req_readdatavalid = rvalid_q;
    assign o_req_readdata      = rdata_q;
    assign o_c_en              = c_en_q;
    assign o_c_wrt             = c_wrt_q;
    assign o_c_addr            = c_addr_q;
    assign o_c_data            = c_data_q;
    assign o_m_read            = m_read_q;
    assign o_m_address         = m_addr_q;
    assign o_hit_cnt           = hit_q;
    assign o_miss_cnt          = miss_q;

endmodule

// File: tb/tb_cache_rd_ctrl.sv
// Bench for cache_rd_ctrl: behavioural cache and SDRAM devices plus a
// transaction-level reference for grant order, hit/miss and returned data.
module tb_cache_rd_ctrl;

    localparam int N = 4, SB = 32, BT = 24, BM = 32;

    logic clk = 1'b0, rst = 1'b1;
    logic [BM-1:0]   base = '0;
    logic [N-1:0]    req_read = '0;
    logic [N*BT-1:0] req_addr = '0;
    logic [N-1:0]    req_wr, req_rdv;
    logic [SB-1:0]   req_rdata;
    logic            c_en, c_wrt;
    logic [BT-1:0]   c_addr;
    logic [SB-1:0]   c_wdata;
    logic [SB-1:0]   c_rdata = '0;
    logic            c_succ = 1'b0;
    logic            m_read, m_wr;
    logic [BM-1:0]   m_addr;
    logic [SB-1:0]   m_rdata = '0;
    logic            m_rdv = 1'b0;
    logic [31:0]     hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_rd_ctrl #(.N_REQ(N), .SIZE_BLOCK(SB), .BIT_TOTAL(BT), .BIT_MEM(BM)) dut (
        .i_clk(clk), .i_rst(rst), .i_base_addr(base),
        .i_req_read(req_read), .i_req_addr(req_addr),
        .o_req_waitrequest(req_wr), .o_req_readdatavalid(req_rdv), .o_req_readdata(req_rdata),
        .o_c_en(c_en), .o_c_wrt(c_wrt), .o_c_addr(c_addr), .o_c_data(c_wdata),
        .i_c_data(c_rdata), .i_c_success(c_succ),
        .o_m_read(m_read), .o_m_address(m_addr), .i_m_waitrequest(m_wr),
        .i_m_readdata(m_rdata), .i_m_readdatavalid(m_rdv),
        .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
    );

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
    endfunction

    // Cache device: registered response one cycle after enable, cleared by reset.
    logic [SB-1:0] cmem [int];
    always @(posedge clk) begin
        if (rst) begin
            c_succ <= 1'b0;
            cmem.delete();
        end else begin
            c_succ <= 1'b0;
            if (c_en && c_wrt) begin
                cmem[int'(c_addr)] = c_wdata;
                c_succ  <= 1'b1;
                c_rdata <= c_wdata;
            end else if (c_en && cmem.exists(int'(c_addr))) begin
                c_succ  <= 1'b1;
                c_rdata <= cmem[int'(c_addr)];
            end
        end
    end

    // SDRAM device: stalls m_wait_cfg cycles per read, answers m_lat_cfg cycles later; ignores i_rst.
    int m_wait_cfg = 0, m_lat_cfg = 1;
    bit m_ovr_en = 1'b0;
    logic [31:0] m_ovr = '0;
    int m_stall = 0, lat_left = 0, m_acc_cnt = 0;
    logic [31:0] m_acc_addr = '0, lat_data = '0;
    assign m_wr = (m_stall < m_wait_cfg);
    always @(posedge clk) begin
        m_rdv <= 1'b0;
        if (m_read && m_wr) begin
            m_stall <= m_stall + 1;
        end else if (m_read) begin
            m_stall    <= 0;
            m_acc_cnt  <= m_acc_cnt + 1;
            m_acc_addr <= m_addr;
            lat_left   <= m_lat_cfg;
            lat_data   <= m_ovr_en ? m_ovr : mem_word(m_addr);
        end else if (lat_left > 0) begin
            lat_left <= lat_left - 1;
            if (lat_left == 1) begin
                m_rdv   <= 1'b1;
                m_rdata <= lat_data;
            end
        end
    end

    // Monitor, sampled mid-cycle.
    typedef struct {int id; logic [SB-1:0] data; int cyc;} resp_t;
    resp_t resp_q[$];
    resp_t mr;
    int fill_cnt = 0, rdv_cyc = 0, mread_cyc = 0, maddr_err = 0;
    int wr_low_cyc = 0, wr_multi = 0, rst_wr_err = 0, onehot_err = 0;
    logic [BT-1:0] fill_addr = '0;
    logic [SB-1:0] fill_data = '0;
    logic [BM-1:0] exp_maddr = '0;
    always @(negedge clk) begin
        if (req_rdv != '0) begin
            if (!$onehot(req_rdv)) onehot_err++;
            for (int k = 0; k < N; k++)
                if (req_rdv[k]) begin
                    mr.id = k; mr.data = req_rdata; mr.cyc = cyc;
                    resp_q.push_back(mr);
                end
        end
        if (c_en && c_wrt) begin
            fill_cnt++; fill_addr = c_addr; fill_data = c_wdata;
        end
        if (m_rdv) rdv_cyc = cyc;
        if (m_read) begin
            mread_cyc++;
            if (m_addr !== exp_maddr) maddr_err++;
        end
        if (req_wr !== '1) begin
            wr_low_cyc++;
            if ($countones(~req_wr) > 1) wr_multi++;
        end
        if (rst && req_wr !== '1) rst_wr_err++;
    end

    // Reference: round-robin order and hit/miss/data from block-level rules.
    int ref_ptr = 0, ref_hits = 0, ref_misses = 0;
    logic [SB-1:0] ref_data [int];

    function automatic void ref_order(input logic [N-1:0] mask, output int ord[$]);
        ord.delete();
        for (int i = 0; i < N; i++)
            if (mask[(ref_ptr + i) % N]) ord.push_back((ref_ptr + i) % N);
        if (ord.size() > 0) ref_ptr = (ord[ord.size()-1] + 1) % N;
    endfunction

    function automatic logic [SB-1:0] ref_access(input int idx, input logic [31:0] b);
        if (ref_data.exists(idx)) begin
            ref_hits++;
        end else begin
            ref_misses++;
            ref_data[idx] = mem_word(32'(longint'(b) + longint'(idx) * (SB / 8)));
        end
        return ref_data[idx];
    endfunction

    function automatic void ref_reset();
        ref_data.delete();
        ref_ptr = 0; ref_hits = 0; ref_misses = 0;
    endfunction

    // Driver: raise the masked reads, drop each one after its acceptance cycle.
    int acc_id_q[$], acc_cyc_q[$];
    task automatic issue(input logic [N-1:0] mask, input logic [N*BT-1:0] addrs, output bit ok);
        logic [N-1:0] pend;
        int g = 0;
        acc_id_q.delete(); acc_cyc_q.delete();
        @(posedge clk); #1;
        req_addr = addrs; req_read = mask; pend = mask;
        while (pend != '0 && g < 300) begin
            @(negedge clk);
            for (int k = 0; k < N; k++)
                if (pend[k] && !req_wr[k]) begin
                    acc_id_q.push_back(k); acc_cyc_q.push_back(cyc); pend[k] = 1'b0;
                end
            @(posedge clk); #1;
            req_read = pend;
            g++;
        end
        req_read = '0;
        ok = (pend == '0);
    endtask

    task automatic wait_resp(input int n, output bit ok);
        int g = 0;
        while (resp_q.size() < n && g < 300) begin
            @(negedge clk); g++;
        end
        repeat (2) @(negedge clk);
        ok = (resp_q.size() == n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 req_read = '1;
        @(negedge clk);
        tests++; if (req_wr !== '1) begin fails++; $display("FAIL reset_waitreq_held got=%b exp=1111", req_wr); end
        @(posedge clk); #1 req_read = '0; rst = 1'b0;
        @(negedge clk);
        tests++; if (req_wr !== '1) begin fails++; $display("FAIL reset_waitreq got=%b exp=1111", req_wr); end
        tests++; if ({req_rdv, c_en, c_wrt, m_read} !== '0) begin fails++; $display("FAIL reset_strobes got=%b exp=0", {req_rdv, c_en, c_wrt, m_read}); end
        tests++; if ({req_rdata, c_addr, c_wdata, m_addr} !== '0) begin fails++; $display("FAIL reset_buses got=%h exp=0", {req_rdata, c_addr, c_wdata, m_addr}); end
        tests++; if (hit_cnt !== 0 || miss_cnt !== 0) begin fails++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    endtask

    task automatic test_cold_miss();
        int ord[$]; bit ok, ok2; int f0;
        base = 32'h1000_0000; exp_maddr = 32'h1000_0014;
        m_ovr_en = 1'b1; m_ovr = 32'hDEAD_BEEF; m_lat_cfg = 4; m_wait_cfg = 0;
        ref_order(4'b0001, ord); ref_misses++; ref_data[5] = 32'hDEAD_BEEF;
        f0 = fill_cnt; resp_q.delete();
        issue(4'b0001, {72'h0, 24'h000005}, ok);
        wait_resp(1, ok2);
        m_ovr_en = 1'b0;
        tests++; if (!(ok && ok2)) begin fails++; $display("FAIL cold_handshake got=%0d%0d exp=11", ok, ok2); end
        tests++; if (m_acc_addr !== 32'h1000_0014) begin fails++; $display("FAIL cold_maddr got=%h exp=10000014", m_acc_addr); end
        tests++; if (fill_cnt - f0 != 1 || fill_addr !== 24'd5 || fill_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL cold_fill got=%0d@%h=%h exp=1@5=deadbeef", fill_cnt - f0, fill_addr, fill_data); end
        tests++; if (resp_q.size() < 1 || resp_q[0].id != ord[0] || resp_q[0].data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL cold_resp got=%0d exp=id0/deadbeef", resp_q.size()); end
        else begin
            tests++; if (resp_q[0].cyc - rdv_cyc != 2) begin fails++; $display("FAIL cold_latency got=%0d exp=2", resp_q[0].cyc - rdv_cyc); end
        end
        tests++; if (miss_cnt !== ref_misses || hit_cnt !== ref_hits) begin
            fails++; $display("FAIL cold_counters got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, ref_hits, ref_misses); end
    endtask

    task automatic test_hit();
        int ord[$]; bit ok, ok2; int a0, mr0; logic [SB-1:0] ed;
        a0 = m_acc_cnt; mr0 = mread_cyc;
        ref_order(4'b0001, ord); ed = ref_access(5, base);
        resp_q.delete();
        issue(4'b0001, {72'h0, 24'h000005}, ok);
        wait_resp(1, ok2);
        tests++; if (!(ok && ok2)) begin fails++; $display("FAIL hit_handshake got=%0d%0d exp=11", ok, ok2); end
        if (ok && ok2) begin
            tests++; if (resp_q[0].cyc - acc_cyc_q[0] != 3) begin fails++; $display("FAIL hit_latency got=%0d exp=3", resp_q[0].cyc - acc_cyc_q[0]); end
            tests++; if (resp_q[0].id != ord[0] || resp_q[0].data !== ed) begin
                fails++; $display("FAIL hit_resp got=%0d/%h exp=%0d/%h", resp_q[0].id, resp_q[0].data, ord[0], ed); end
        end
        tests++; if (m_acc_cnt != a0 || mread_cyc != mr0) begin fails++; $display("FAIL hit_no_mread got=%0d exp=0", mread_cyc - mr0); end
        tests++; if (hit_cnt !== ref_hits) begin fails++; $display("FAIL hit_count got=%0d exp=%0d", hit_cnt, ref_hits); end
    endtask

    task automatic test_round_robin();
        int ord[$]; int exp_ids[$]; int got_ids[$]; bit ok, ok2; int wl0, g; logic [SB-1:0] ed;
        // Requester 3 first, so the pointer sits at 0 for the all-request burst.
        ref_order(4'b1000, ord); ed = ref_access(5, base);
        resp_q.delete();
        issue(4'b1000, {4{24'h000005}}, ok);
        wait_resp(1, ok2);
        tests++; if (!ok || !ok2 || resp_q[0].id != ord[0]) begin fails++; $display("FAIL rr_prime got=%0d%0d exp=11", ok, ok2); end
        for (int i = 0; i < 5; i++) begin
            exp_ids.push_back(ref_ptr);
            ref_ptr = (ref_ptr + 1) % N;
            ed = ref_access(5, base);
        end
        resp_q.delete(); wl0 = wr_low_cyc; g = 0;
        @(posedge clk); #1 req_read = '1;
        while (got_ids.size() < 5 && g < 300) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (!req_wr[k]) got_ids.push_back(k);
            @(posedge clk); #1;
            if (got_ids.size() >= 5) req_read = '0;
            g++;
        end
        req_read = '0;
        wait_resp(5, ok2);
        tests++; if (got_ids.size() != 5 || !ok2) begin fails++; $display("FAIL rr_count got=%0d/%0d exp=5/5", got_ids.size(), resp_q.size()); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (i >= got_ids.size() || i >= resp_q.size() || got_ids[i] != exp_ids[i] || resp_q[i].id != exp_ids[i] || resp_q[i].data !== ed) begin
                fails++; $display("FAIL rr_grant%0d exp=%0d", i, exp_ids[i]); end
        end
        tests++; if (wr_low_cyc - wl0 != 5 || wr_multi != 0) begin
            fails++; $display("FAIL rr_waitreq_low got=%0d multi=%0d exp=5 multi=0", wr_low_cyc - wl0, wr_multi); end
        tests++; if (hit_cnt !== ref_hits) begin fails++; $display("FAIL rr_hits got=%0d exp=%0d", hit_cnt, ref_hits); end
    endtask

    task automatic test_backpressure();
        int ord[$]; bit ok, ok2; int mr0, me0, a0; logic [SB-1:0] ed;
        base = 32'h2000_0000; exp_maddr = 32'h2000_048C;
        m_wait_cfg = 10; m_lat_cfg = 3;
        mr0 = mread_cyc; me0 = maddr_err; a0 = m_acc_cnt;
        ref_order(4'b0010, ord); ed = ref_access(24'h123, base);
        resp_q.delete();
        issue(4'b0010, {48'h0, 24'h000123, 24'h0}, ok);
        wait_resp(1, ok2);
        m_wait_cfg = 0;
        tests++; if (mread_cyc - mr0 != 11) begin fails++; $display("FAIL bp_read_cycles got=%0d exp=11", mread_cyc - mr0); end
        tests++; if (maddr_err != me0) begin fails++; $display("FAIL bp_addr_stable got=%0d exp=0", maddr_err - me0); end
        tests++; if (m_acc_cnt - a0 != 1 || m_acc_addr !== exp_maddr) begin
            fails++; $display("FAIL bp_accepted got=%0d@%h exp=1@%h", m_acc_cnt - a0, m_acc_addr, exp_maddr); end
        tests++; if (!ok || !ok2 || resp_q[0].id != ord[0] || resp_q[0].data !== ed) begin
            fails++; $display("FAIL bp_resp got=%0d exp=1 data %h", resp_q.size(), ed); end
        tests++; if (miss_cnt !== ref_misses) begin fails++; $display("FAIL bp_misses got=%0d exp=%0d", miss_cnt, ref_misses); end
    endtask

    task automatic test_random();
        int ord[$]; int ia[N]; logic [N-1:0] mask; logic [N*BT-1:0] av; logic [SB-1:0] ed[$]; bit ok, ok2;
        base = 32'h0004_0000;
        for (int r = 0; r < 24; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            av = '0;
            for (int k = 0; k < N; k++) begin
                ia[k] = $urandom_range(0, 11);
                av[k*BT +: BT] = BT'(ia[k]);
            end
            m_wait_cfg = $urandom_range(0, 3); m_lat_cfg = $urandom_range(1, 5);
            ref_order(mask, ord);
            ed.delete();
            foreach (ord[i]) ed.push_back(ref_access(ia[ord[i]], base));
            resp_q.delete();
            issue(mask, av, ok);
            wait_resp(ord.size(), ok2);
            tests++; if (!(ok && ok2)) begin fails++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, resp_q.size(), ord.size()); end
            for (int i = 0; i < ord.size(); i++) begin
                tests++;
                if (i >= acc_id_q.size() || i >= resp_q.size() || acc_id_q[i] != ord[i] || resp_q[i].id != ord[i] || resp_q[i].data !== ed[i]) begin
                    fails++; $display("FAIL rnd%0d_txn%0d exp=id%0d/%h", r, i, ord[i], ed[i]); end
            end
        end
        m_wait_cfg = 0;
        tests++; if (hit_cnt !== ref_hits || miss_cnt !== ref_misses) begin
            fails++; $display("FAIL rnd_counters got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, ref_hits, ref_misses); end
    endtask

    task automatic test_reset_mid_miss();
        int ord[$]; bit ok; int f0, a0, g = 0;
        base = 32'h3000_0000; m_lat_cfg = 8; m_wait_cfg = 0;
        f0 = fill_cnt; a0 = m_acc_cnt; resp_q.delete();
        issue(4'b0100, {24'h0, 24'h000077, 48'h0}, ok);
        while (m_acc_cnt == a0 && g < 100) begin @(negedge clk); g++; end
        tests++; if (!ok || m_acc_cnt == a0) begin fails++; $display("FAIL rstmiss_reach_mwait got=%0d exp=1", m_acc_cnt - a0); end
        @(posedge clk); #1 rst = 1'b1; req_read[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req_read = '0;
        ref_reset();
        repeat (15) @(negedge clk);
        tests++; if (fill_cnt != f0) begin fails++; $display("FAIL rstmiss_fill got=%0d exp=0", fill_cnt - f0); end
        tests++; if (resp_q.size() != 0) begin fails++; $display("FAIL rstmiss_resp got=%0d exp=0", resp_q.size()); end
        tests++; if (rst_wr_err != 0) begin fails++; $display("FAIL rstmiss_waitreq got=%0d exp=0", rst_wr_err); end
        tests++; if (hit_cnt !== 0 || miss_cnt !== 0 || m_read !== 1'b0) begin
            fails++; $display("FAIL rstmiss_state got=%0d/%0d/%b exp=0/0/0", hit_cnt, miss_cnt, m_read); end
    endtask

    task automatic test_addr_wrap();
        int ord[$]; bit ok, ok2; logic [SB-1:0] ed;
        base = 32'hFFFF_FFF0; exp_maddr = 32'h0000_0010; m_lat_cfg = 2;
        ref_order(4'b1000, ord); ed = ref_access(8, base);
        resp_q.delete();
        issue(4'b1000, {24'h000008, 72'h0}, ok);
        wait_resp(1, ok2);
        tests++; if (m_acc_addr !== 32'h0000_0010) begin fails++; $display("FAIL wrap_maddr got=%h exp=00000010", m_acc_addr); end
        tests++; if (!ok || !ok2 || resp_q[0].id != ord[0] || resp_q[0].data !== ed) begin
            fails++; $display("FAIL wrap_resp got=%0d exp=1 data %h", resp_q.size(), ed); end
        tests++; if (miss_cnt !== ref_misses || hit_cnt !== ref_hits) begin
            fails++; $display("FAIL wrap_counters got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, ref_hits, ref_misses); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_mid_miss();
        test_addr_wrap();
        tests++; if (onehot_err != 0) begin fails++; $display("FAIL resp_onehot got=%0d exp=0", onehot_err); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
